// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the fetch sequencer
//
// Purpose: FSM state encoding, next-PC select encoding, PC increment and
//          small helpers shared by pc_fetch_sequencer and pc_adder.
// Ports:   none (package).
package mips_pkg;

   localparam logic [31:0] PC_INC = 32'd4;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_WAIT = 2'd2,
      ST_HALT = 2'd3
   } fetch_state_e;

   typedef enum logic [2:0] {
      SEL_SEQ  = 3'd0,
      SEL_BR   = 3'd1,
      SEL_J    = 3'd2,
      SEL_JR   = 3'd3,
      SEL_HOLD = 3'd4
   } pc_sel_e;

   // Redirects win over Stall: once control flow is resolved the old
   // sequential path is dead, so holding it would only fetch garbage.
   function automatic pc_sel_e pick_pc_sel(input logic jump_reg,
                                           input logic jump,
                                           input logic branch_taken,
                                           input logic stall);
      pc_sel_e sel;
      if (jump_reg)          sel = SEL_JR;
      else if (jump)         sel = SEL_J;
      else if (branch_taken) sel = SEL_BR;
      else if (stall)        sel = SEL_HOLD;
      else                   sel = SEL_SEQ;
      return sel;
   endfunction

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/pc_fetch_sequencer_pc_adder.sv
// rtl/pc_fetch_sequencer_pc_adder.sv - PCAdder, sequential next address
//
// Purpose: produces PC + PC_INC, wrapping modulo 2^32 with no carry out.
// Ports:   pc_i        current PC
//          pc_plus4_o  pc_i + 4
module pc_adder
   import mips_pkg::*;
(
   input  logic [31:0] pc_i,
   output logic [31:0] pc_plus4_o
);

   assign pc_plus4_o = pc_i + PC_INC;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// rtl/pc_fetch_sequencer.sv - program counter owner and fetch sequencer
//
// Purpose: holds the PC, picks the next PC (seq / branch / jump / jr / hold),
//          waits on instruction memory, and sequences BOOT/RUN/WAIT/HALT.
// Ports:   Clk, Reset (async active-low)
//          Stall, BranchTaken/BranchTarget, Jump/JumpTarget,
//          JumpReg/RegTarget, Halt, IMemReady      control inputs
//          PCResult     registered PC
//          PCAddResult  PCResult + 4
//          FetchValid   PCResult is a live fetch request (RUN/WAIT)
//          Flush        pulse after a redirect edge
//          AlignErr     pulse after a redirect whose raw target was misaligned
//          Halted       FSM in HALT
module pc_fetch_sequencer
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          BOOT_CYCLES = 2
)
(
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Stall,
   input  logic        BranchTaken,
   input  logic [31:0] BranchTarget,
   input  logic        Jump,
   input  logic [31:0] JumpTarget,
   input  logic        JumpReg,
   input  logic [31:0] RegTarget,
   input  logic        Halt,
   input  logic        IMemReady,
   output logic [31:0] PCResult,
   output logic [31:0] PCAddResult,
   output logic        FetchValid,
   output logic        Flush,
   output logic        AlignErr,
   output logic        Halted
);

   localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};
   localparam logic [3:0]  BOOT_LAST  = 4'(BOOT_CYCLES);

   fetch_state_e state_q, state_d;
   logic [3:0]   boot_cnt_q, boot_cnt_d;
   logic [31:0]  pc_q, pc_d;
   logic         flush_q, flush_d;
   logic         align_err_q, align_err_d;

   logic [31:0]  pc_plus4;
   logic [31:0]  redirect_target;
   logic         redirect;
   logic         apply_sel;
   pc_sel_e      pc_sel;

   pc_adder u_pc_adder (
      .pc_i       (pc_q),
      .pc_plus4_o (pc_plus4)
   );

   always_comb begin
      pc_sel   = pick_pc_sel(JumpReg, Jump, BranchTaken, Stall);
      redirect = JumpReg | Jump | BranchTaken;
      case (pc_sel)
         SEL_JR:  redirect_target = RegTarget;
         SEL_J:   redirect_target = JumpTarget;
         default: redirect_target = BranchTarget;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      boot_cnt_d  = boot_cnt_q;
      pc_d        = pc_q;
      flush_d     = 1'b0;
      align_err_d = 1'b0;
      apply_sel   = 1'b0;

      case (state_q)
         ST_BOOT: begin
            // The count reaches BOOT_LAST on the BOOT_CYCLES-th edge; the
            // following edge enters RUN.
            if (boot_cnt_q == BOOT_LAST) state_d = ST_RUN;
            else                         boot_cnt_d = boot_cnt_q + 4'd1;
         end
         ST_RUN: begin
            if (Halt)                         state_d = ST_HALT;
            else if (!IMemReady && !redirect) state_d = ST_WAIT;
            else                              apply_sel = 1'b1;
         end
         ST_WAIT: begin
            if (Halt) begin
               state_d = ST_HALT;
            end else if (redirect || IMemReady) begin
               // A redirect abandons the outstanding fetch without
               // waiting for memory to accept it.
               apply_sel = 1'b1;
               state_d   = ST_RUN;
            end
         end
         default: ;
      endcase

      if (apply_sel) begin
         case (pc_sel)
            SEL_SEQ:  pc_d = pc_plus4;
            SEL_HOLD: pc_d = pc_q;
            default: begin
               pc_d        = word_align(redirect_target);
               flush_d     = 1'b1;
               align_err_d = |redirect_target[1:0];
            end
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q     <= ST_BOOT;
         boot_cnt_q  <= 4'd0;
         pc_q        <= RESET_PC_W;
         flush_q     <= 1'b0;
         align_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         boot_cnt_q  <= boot_cnt_d;
         pc_q        <= pc_d;
         flush_q     <= flush_d;
         align_err_q <= align_err_d;
      end
   end

   assign PCResult    = pc_q;
   assign PCAddResult = pc_plus4;
   assign FetchValid  = (state_q == ST_RUN) || (state_q == ST_WAIT);
   assign Halted      = (state_q == ST_HALT);
   assign Flush       = flush_q;
   assign AlignErr    = align_err_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb/tb_pc_fetch_sequencer.sv - scoreboard bench for pc_fetch_sequencer
module tb_pc_fetch_sequencer;

   localparam int BOOT = 2;

   logic        clk;
   logic        rst_n;
   logic        stall, br, j, jr, halt, ready;
   logic [31:0] bt, jt, rt;
   logic [31:0] pc_result, pc_add_result;
   logic        fetch_valid, flush, align_err, halted;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [31:0] pc;
      logic        fv;
      logic        flush;
      logic        align;
      logic        halted;
   } exp_t;

   exp_t sb[$];

   int          m_state;
   int          m_cnt;
   logic [31:0] m_pc;
   logic        m_flush, m_align;

   pc_fetch_sequencer #(
      .RESET_PC    (32'h0000_0000),
      .BOOT_CYCLES (BOOT)
   ) dut (
      .Clk          (clk),
      .Reset        (rst_n),
      .Stall        (stall),
      .BranchTaken  (br),
      .BranchTarget (bt),
      .Jump         (j),
      .JumpTarget   (jt),
      .JumpReg      (jr),
      .RegTarget    (rt),
      .Halt         (halt),
      .IMemReady    (ready),
      .PCResult     (pc_result),
      .PCAddResult  (pc_add_result),
      .FetchValid   (fetch_valid),
      .Flush        (flush),
      .AlignErr     (align_err),
      .Halted       (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_in();
      stall = 0; br = 0; j = 0; jr = 0; halt = 0; ready = 1;
      bt = 0; jt = 0; rt = 0;
   endtask

   task automatic model_reset();
      m_state = 0; m_cnt = 0; m_pc = 32'h0; m_flush = 0; m_align = 0;
   endtask

   task automatic model_edge();
      logic        redir;
      logic [31:0] tgt;
      logic        take;
      redir = jr | j | br;
      tgt   = jr ? rt : (j ? jt : bt);
      take  = 0;
      m_flush = 0;
      m_align = 0;
      case (m_state)
         0: if (m_cnt == BOOT) m_state = 1; else m_cnt++;
         1: if (halt) m_state = 3;
            else if (!ready && !redir) m_state = 2;
            else take = 1;
         2: if (halt) m_state = 3;
            else if (redir || ready) begin take = 1; m_state = 1; end
         default: ;
      endcase
      if (take) begin
         if (redir) begin
            m_pc    = tgt & 32'hFFFF_FFFC;
            m_flush = 1;
            m_align = (tgt[1:0] != 2'b00);
         end else if (!stall) begin
            m_pc = m_pc + 32'd4;
         end
      end
   endtask

   // Inputs are already set; push the expected post-edge outputs, take the
   // edge, then pop and compare just after it.
   task automatic step();
      exp_t e;
      exp_t got;
      model_edge();
      e.pc     = m_pc;
      e.fv     = (m_state == 1) || (m_state == 2);
      e.flush  = m_flush;
      e.align  = m_align;
      e.halted = (m_state == 3);
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk("sb_empty", 32'd0, 32'd1);
      end else begin
         got = sb.pop_front();
         chk("pc", pc_result, got.pc);
         chk("pc_add", pc_add_result, got.pc + 32'd4);
         chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, got.fv});
         chk("flush", {31'd0, flush}, {31'd0, got.flush});
         chk("align_err", {31'd0, align_err}, {31'd0, got.align});
         chk("halted", {31'd0, halted}, {31'd0, got.halted});
      end
      @(negedge clk);
   endtask

   task automatic jump_to(input logic [31:0] a);
      clear_in(); j = 1; jt = a; step(); clear_in();
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_pc"}, pc_result, 32'h0);
      chk({tag, "_fv"}, {31'd0, fetch_valid}, 32'd0);
      chk({tag, "_flush"}, {31'd0, flush}, 32'd0);
      chk({tag, "_align"}, {31'd0, align_err}, 32'd0);
      chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
   endtask

   initial begin
      clear_in();
      rst_n = 0;
      model_reset();
      repeat (3) @(negedge clk);
      chk_reset_vals("rst");
      rst_n = 1;

      // Boot: FetchValid rises on the third edge after release.
      step(); chk("boot1_fv", {31'd0, fetch_valid}, 32'd0);
      step(); chk("boot2_fv", {31'd0, fetch_valid}, 32'd0);
      step(); chk("boot3_fv", {31'd0, fetch_valid}, 32'd1);
      chk("seq0", pc_result, 32'h0);
      step(); chk("seq4", pc_result, 32'h4);
      step(); chk("seq8", pc_result, 32'h8);
      step(); chk("seq12", pc_result, 32'hC);

      // Jump beats branch.
      jump_to(32'h40);
      br = 1; bt = 32'h100; j = 1; jt = 32'h200; step(); clear_in();
      chk("j_over_br", pc_result, 32'h200);
      chk("j_over_br_flush", {31'd0, flush}, 32'd1);
      step();
      chk("flush_one_cycle", {31'd0, flush}, 32'd0);

      // Misaligned jr.
      jump_to(32'h40);
      jr = 1; rt = 32'h33; step(); clear_in();
      chk("jr_align_pc", pc_result, 32'h30);
      chk("jr_align_err", {31'd0, align_err}, 32'd1);
      step();

      // Stall hold, then a jump overrides Stall.
      jump_to(32'h20);
      stall = 1;
      repeat (3) step();
      chk("stall_hold", pc_result, 32'h20);
      j = 1; jt = 32'h80; step(); clear_in();
      chk("jump_over_stall", pc_result, 32'h80);

      // IMem wait states.
      jump_to(32'h10);
      ready = 0; step(); step();
      chk("wait_hold", pc_result, 32'h10);
      ready = 1; step();
      chk("wait_adv", pc_result, 32'h14);
      ready = 0; step();
      br = 1; bt = 32'h60; step(); clear_in();
      chk("wait_redirect", pc_result, 32'h60);
      chk("wait_redirect_flush", {31'd0, flush}, 32'd1);

      // Wraparound.
      jump_to(32'hFFFF_FFFC);
      step();
      chk("wrap", pc_result, 32'h0);

      // Random traffic, no halt.
      for (int i = 0; i < 60; i++) begin
         clear_in();
         stall = ($urandom_range(0, 3) == 0);
         ready = ($urandom_range(0, 3) != 0);
         br = ($urandom_range(0, 5) == 0); bt = $urandom;
         j  = ($urandom_range(0, 7) == 0); jt = $urandom;
         jr = ($urandom_range(0, 9) == 0); rt = $urandom;
         step();
      end
      clear_in();
      step();

      // Halt, then frozen despite Jump/Stall.
      jump_to(32'h24);
      halt = 1; j = 1; jt = 32'h300; step(); clear_in();
      chk("halt_pc", pc_result, 32'h24);
      chk("halt_flag", {31'd0, halted}, 32'd1);
      chk("halt_fv", {31'd0, fetch_valid}, 32'd0);
      j = 1; jt = 32'h400; stall = 1; step();
      clear_in(); step();
      chk("halt_frozen", pc_result, 32'h24);

      // Asynchronous reset pulse between edges.
      #1 rst_n = 0;
      #1 chk_reset_vals("async_rst");
      #1 rst_n = 1;
      model_reset();
      step(); step(); step();
      chk("reboot_fv", {31'd0, fetch_valid}, 32'd1);
      step();
      chk("reboot_seq", pc_result, 32'h4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
